// File: rtl/mult_seq_pkg.sv
// Shared op encodings and FSM state type for the sequential multiplier.
package mult_seq_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_lane.sv
// Combinational signed (XLEN+1) x (LANE_W+1) partial-product multiplier.
module mult_seq_lane #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned LANE_W = 8
) (
  input  logic [XLEN:0]          a_i,
  input  logic [LANE_W:0]        b_i,
  output logic [XLEN+LANE_W+1:0] p_o
);

  localparam int unsigned PW = XLEN + LANE_W + 2;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;

  always_comb begin
    a_x = {{(LANE_W + 1){a_i[XLEN]}}, a_i};
    b_x = {{(XLEN + 1){b_i[LANE_W]}}, b_i};
    p_o = a_x * b_x;
  end

endmodule

// File: rtl/mult_seq_core.sv
// Radix-2^LANE_W sequential multiplier (MUL/MULH/MULHSU/MULHU), one slice per cycle.
// Optional zero-operand early-out: define MULT_SEQ_EARLY_OUT_EN.
module mult_seq_core
  import mult_seq_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned LANE_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned N  = XLEN / LANE_W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = XLEN + LANE_W + 2;

  if (!((LANE_W == 4) || (LANE_W == 8) || (LANE_W == 16) || (LANE_W == 32)) ||
      ((XLEN % LANE_W) != 0)) begin : g_bad_cfg
    $error("mult_seq_core: LANE_W must be 4/8/16/32 and divide XLEN");
  end

  state_e            state_q, state_d;
  logic [XLEN:0]     a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              b_signed_q, b_signed_d;
  logic              hi_q, hi_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [KW-1:0]     k_q, k_d;

  logic                     req_ready;
  logic                     req_fire;
  logic                     a_signed;
  logic [XLEN-1:0]          b_shift;
  logic [LANE_W-1:0]        slice;
  logic [LANE_W:0]          slice_ext;
  logic [PW-1:0]            p_lane;
  logic signed [2*XLEN-1:0] p_ext;
  logic [2*XLEN-1:0]        addend;

  assign a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU);

  // Only the top slice of a signed B carries the sign; lower slices are magnitude digits.
  always_comb begin
    b_shift   = b_q >> (k_q * LANE_W);
    slice     = b_shift[LANE_W-1:0];
    slice_ext = {b_signed_q && (k_q == KW'(N - 1)) && slice[LANE_W-1], slice};
    p_ext     = (2*XLEN)'($signed(p_lane));
    addend    = p_ext << (k_q * LANE_W);
  end

  mult_seq_lane #(
    .XLEN   (XLEN),
    .LANE_W (LANE_W)
  ) u_lane (
    .a_i (a_q),
    .b_i (slice_ext),
    .p_o (p_lane)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    b_signed_d = b_signed_q;
    hi_d       = hi_q;
    acc_d      = acc_q;
    k_d        = k_q;
    req_ready  = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && rsp_ready_i)) && !flush_i;
    req_fire   = req_valid_i && req_ready;

    if (flush_i) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          acc_d = acc_q + addend;
          if (k_q == KW'(N - 1)) begin
            k_d     = '0;
            state_d = ST_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: begin
          // DONE shares the accept path with IDLE so back-to-back requests skip the idle bubble.
          if (req_fire) begin
            a_d        = {a_signed & op_a_i[XLEN-1], op_a_i};
            b_d        = op_b_i;
            b_signed_d = (op_i == OP_MULH);
            hi_d       = (op_i != OP_MUL);
            acc_d      = '0;
            k_d        = '0;
            state_d    = ST_BUSY;
`ifdef MULT_SEQ_EARLY_OUT_EN
            if ((op_a_i == '0) || (op_b_i == '0)) begin
              state_d = ST_DONE;
            end
`else
`endif
          end else if ((state_q == ST_DONE) && rsp_ready_i) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      b_signed_q <= 1'b0;
      hi_q       <= 1'b0;
      acc_q      <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      b_signed_q <= b_signed_d;
      hi_q       <= hi_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
    end
  end

  assign req_ready_o = req_ready;
  assign rsp_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign result_o    = rsp_valid_o ? (hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0]) : '0;

endmodule

// File: tb/tb_mult_seq_core.sv
// Directed + scoreboard bench for mult_seq_core (XLEN=32, LANE_W=8).
module tb_mult_seq_core;
  import mult_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  mult_seq_core #(
    .XLEN   (32),
    .LANE_W (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .op_i        (op_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be, p;
    ae = {{32{((op == 2'b01) || (op == 2'b10)) && a[31]}}, a};
    be = {{32{(op == 2'b01) && b[31]}}, b};
    p  = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SEQ_EARLY_OUT_EN
    if ((a == 32'd0) || (b == 32'd0)) return 32'd1;
`endif
    return 32'd5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy_o},      32'd0);
    check({tag, "_result"},    result_o,             32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the handshake.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_rsp);
    int unsigned n = 0;
    op_i = op; op_a_i = a; op_b_i = b; req_valid_i = 1'b1;
    #1;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    if (!req_ready_o) check("accept_timeout", {31'd0, req_ready_o}, 32'd1);
    else if (expect_rsp) exp_q.push_back(model(op, a, b));
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output logic [31:0] lat);
    logic [31:0] e;
    lat = 32'd1;
    while (!rsp_valid_o && lat < 32'd20) begin
      @(negedge clk_i); lat++;
    end
    if (!rsp_valid_o) begin
      check({tag, "_rsp_timeout"}, {31'd0, rsp_valid_o}, 32'd1);
    end else begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL %s_unexpected_rsp observed=0x%08h expected=none", tag, result_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, "_result"}, result_o, e);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lat;
    issue(op, a, b, 1'b1);
    wait_rsp(tag, lat);
    check({tag, "_latency"}, lat, exp_lat(a, b));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lat;
    logic [31:0] held;
    logic        saw;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    op_i = OP_MUL; op_a_i = '0; op_b_i = '0;
    repeat (2) @(negedge clk_i);
    check_reset_vals("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Basic MUL with busy observation in the first BUSY cycle.
    issue(OP_MUL, 32'h0000_0007, 32'h0000_0006, 1'b1);
    check("mul7x6_busy", {31'd0, busy_o}, 32'd1);
    wait_rsp("mul7x6", lat);
    check("mul7x6_latency", lat, 32'd5);
    @(negedge clk_i);

    run_op("mulh_ff",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF); @(negedge clk_i);
    run_op("mulhu_ff",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF); @(negedge clk_i);
    run_op("mulhsu_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); @(negedge clk_i);
    run_op("mul_neg",   OP_MUL,    32'h8000_0001, 32'hFFFF_FFFD); @(negedge clk_i);
    run_op("mulh_mix",  OP_MULH,   32'h8000_0000, 32'h7FFF_FFFF); @(negedge clk_i);
    run_op("mulhsu_mx", OP_MULHSU, 32'h1234_5678, 32'h8765_4321); @(negedge clk_i);
    run_op("mulh_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000); @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      run_op("rand", rop, ra, rb);
      @(negedge clk_i);
    end

    // Back-to-back: second request accepted in the DONE cycle of the first.
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    wait_rsp("b2b_first", lat);
    check("b2b_first_latency", lat, 32'd5);
    check("b2b_done_req_ready", {31'd0, req_ready_o}, 32'd1);
    issue(OP_MUL, 32'h0001_0003, 32'h0002_0005, 1'b1);
    wait_rsp("b2b_second", lat);
    check("b2b_second_gap", lat, 32'd5);
    @(negedge clk_i);

    // Consumer stall: result held, request blocked until rsp_ready rises.
    rsp_ready_i = 1'b0;
    issue(OP_MULH, 32'hFFFF_FF00, 32'h0000_1234, 1'b1);
    wait_rsp("stall", lat);
    held = result_o;
    op_i = OP_MUL; op_a_i = 32'd11; op_b_i = 32'd13; req_valid_i = 1'b1;
    exp_q.push_back(model(OP_MUL, 32'd11, 32'd13));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
      check("stall_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("stall_result_hold", result_o, held);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    #1;
    check("stall_release_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("stall_accept_busy", {31'd0, busy_o}, 32'd1);
    check("stall_accept_novalid", {31'd0, rsp_valid_o}, 32'd0);
    wait_rsp("stall_next", lat);
    check("stall_next_latency", lat, 32'd5);
    @(negedge clk_i);

    // Flush in the second BUSY cycle.
    issue(OP_MUL, 32'd9, 32'd9, 1'b0);
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    check("flush_req_ready", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw |= rsp_valid_o;
      @(negedge clk_i);
    end
    check("flush_no_rsp", {31'd0, saw}, 32'd0);
    issue(OP_MUL, 32'd3, 32'd5, 1'b1);
    wait_rsp("flush_then_mul", lat);
    check("flush_then_mul_direct", result_o, 32'd15);
    @(negedge clk_i);

    // Zero operand: early-out latency depends on build.
    run_op("zero_a", OP_MUL, 32'd0, 32'h1234_5678); @(negedge clk_i);
    run_op("zero_b", OP_MULHU, 32'h8765_4321, 32'd0); @(negedge clk_i);

    // Async reset in the middle of BUSY drops the operation.
    issue(OP_MUL, 32'd5, 32'd7, 1'b0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_reset_vals("midreset");
    @(negedge clk_i);
    rst_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw |= rsp_valid_o;
      @(negedge clk_i);
    end
    check("midreset_no_rsp", {31'd0, saw}, 32'd0);
    run_op("post_reset", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk_i);

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
